// File: rtl/gate_resp_checker.sv
// gate_resp_checker: compacts DUT output words into a MISR signature, counts per-vector mismatches, reports pass/fail
// ports: cycle/rst_n clock and async active-low reset; start/num_vec/exp_sig begin a run;
//        in_valid/in_ready/in_data/in_exp vector stream; busy/done/pass/mismatch_cnt/final_sig status.
// optional: GATE_CHK_FIRST_FAIL_EN adds first_fail_vld/first_fail_idx (index of first mismatching vector)
module gate_resp_checker #(
  parameter int          WIDTH = 32,
  parameter int          CNT_W = 8,
  parameter logic [31:0] POLY  = 32'h04C1_1DB7,
  parameter logic [31:0] SEED  = 32'h0000_0000
) (
  input  logic             cycle,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [0:WIDTH-1] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  input  logic [0:WIDTH-1] in_exp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mismatch_cnt,
`ifdef GATE_CHK_FIRST_FAIL_EN
  output logic             first_fail_vld,
  output logic [CNT_W-1:0] first_fail_idx,
`endif
  output logic [0:WIDTH-1] final_sig
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [0:WIDTH-1] POLY_W = WIDTH'(POLY);
  localparam logic [0:WIDTH-1] SEED_W = WIDTH'(SEED);
  state_t           state_q, state_d;
  logic [0:WIDTH-1] sig_q, sig_d, exp_q, exp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, nv_q, nv_d, mm_q, mm_d;
  logic             pass_q, pass_d, miss;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic             ffv_q, ffv_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
`endif
  assign in_ready     = state_q == RUN;
  assign busy         = in_ready;
  assign done         = state_q == DONE;
  assign pass         = pass_q;
  assign mismatch_cnt = mm_q;
  assign final_sig    = sig_q;
  assign miss         = in_data != in_exp;
`ifdef GATE_CHK_FIRST_FAIL_EN
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;
`endif
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    mm_d    = mm_q;
    pass_d  = pass_q;
`ifdef GATE_CHK_FIRST_FAIL_EN
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
`endif
    if (start && state_q != RUN) begin
      nv_d    = num_vec;
      exp_d   = exp_sig;
      sig_d   = SEED_W;
      cnt_d   = '0;
      mm_d    = '0;
      pass_d  = num_vec == '0 && SEED_W == exp_sig;
      state_d = num_vec == '0 ? DONE : RUN;
`ifdef GATE_CHK_FIRST_FAIL_EN
      ffv_d   = 1'b0;
      ffi_d   = '0;
`endif
    end else if (in_valid && state_q == RUN) begin
      // bit 0 is the MSB, so <<1 moves toward bit 0 and sig_q[0] is the bit shifted out
      sig_d = (sig_q << 1) ^ (sig_q[0] ? POLY_W : '0) ^ in_data;
      mm_d  = mm_q + CNT_W'(miss && !(&mm_q));
      cnt_d = cnt_q + CNT_W'(1);
`ifdef GATE_CHK_FIRST_FAIL_EN
      ffv_d = ffv_q || miss;
      ffi_d = miss && !ffv_q ? cnt_q : ffi_q;
`endif
      if (cnt_q == nv_q - CNT_W'(1)) begin
        state_d = DONE;
        pass_d  = sig_d == exp_q && mm_d == '0;
      end
    end
  end
  always_ff @(posedge cycle or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= SEED_W;
      exp_q   <= '0;
      cnt_q   <= '0;
      nv_q    <= '0;
      mm_q    <= '0;
      pass_q  <= 1'b0;
`ifdef GATE_CHK_FIRST_FAIL_EN
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
      mm_q    <= mm_d;
      pass_q  <= pass_d;
`ifdef GATE_CHK_FIRST_FAIL_EN
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
`endif
    end
  end
endmodule

// File: tb/tb_gate_resp_checker.sv
// tb_gate_resp_checker: randomized self-checking bench for gate_resp_checker against a behavioural MISR model
module tb_gate_resp_checker;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  logic        cycle = 0, rst_n = 0;
  logic        start = 0, in_valid = 0, in_ready, busy, done, pass;
  logic [7:0]  num_vec = 0, mismatch_cnt;
  logic [0:31] exp_sig = 0, in_data = 0, in_exp = 0, final_sig;
`ifdef GATE_CHK_FIRST_FAIL_EN
  logic        first_fail_vld;
  logic [7:0]  first_fail_idx;
  logic        fb_ffv;
  logic [7:0]  fb_ffi;
`endif
  logic        fb_start = 0, fb_valid = 0, fb_ready, fb_busy, fb_done, fb_pass;
  logic [7:0]  fb_nv = 0, fb_mm;
  logic [0:31] fb_es = 0, fb_data = 0, fb_sig;
  int errors = 0, checks = 0;
  logic [31:0] qd[$], qe[$];
  int          qs[$];
  bit          poke;
  gate_resp_checker dut (
    .cycle(cycle), .rst_n(rst_n), .start(start), .num_vec(num_vec), .exp_sig(exp_sig),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_exp(in_exp),
    .busy(busy), .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .first_fail_vld(first_fail_vld), .first_fail_idx(first_fail_idx),
`endif
    .final_sig(final_sig));
  gate_resp_checker #(.SEED(32'h8000_0000)) dut_fb (
    .cycle(cycle), .rst_n(rst_n), .start(fb_start), .num_vec(fb_nv), .exp_sig(fb_es),
    .in_valid(fb_valid), .in_ready(fb_ready), .in_data(fb_data), .in_exp(fb_data),
    .busy(fb_busy), .done(fb_done), .pass(fb_pass), .mismatch_cnt(fb_mm),
`ifdef GATE_CHK_FIRST_FAIL_EN
    .first_fail_vld(fb_ffv), .first_fail_idx(fb_ffi),
`endif
    .final_sig(fb_sig));
  always #5 cycle = ~cycle;
  task automatic tick;
    @(posedge cycle);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] step(input logic [31:0] s, input logic [31:0] d);
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ d;
  endfunction
  function automatic logic [31:0] sig_of();
    logic [31:0] s = 0;
    foreach (qd[i]) s = step(s, qd[i]);
    return s;
  endfunction
  task automatic run(input logic [31:0] es);
    logic [31:0] s = 0;
    int mm = 0, ffi = 0;
    bit ffv = 0;
    start = 1; num_vec = 8'(qd.size()); exp_sig = es;
    tick;
    start = 0; num_vec = 8'($urandom); exp_sig = $urandom;
    check("run_busy", busy, 1);
    check("run_ready", in_ready, 1);
    foreach (qd[i]) begin
      for (int k = 0; k < qs[i]; k++) begin
        start = poke && k == 0; num_vec = 0;
        in_data = $urandom;
        tick;
        check("stall_busy", busy, 1);
        check("stall_done", done, 0);
      end
      start = 0;
      in_valid = 1; in_data = qd[i]; in_exp = qe[i];
      if (qd[i] != qe[i]) begin
        if (!ffv) ffi = i;
        ffv = 1;
        mm = mm == 255 ? 255 : mm + 1;
      end
      s = step(s, qd[i]);
      tick;
      in_valid = 0;
    end
    check("end_done", done, 1);
    check("end_busy", busy, 0);
    check("end_sig", final_sig, s);
    check("end_mm", mismatch_cnt, 32'(mm));
    check("end_pass", pass, 32'(s == es && mm == 0));
`ifdef GATE_CHK_FIRST_FAIL_EN
    check("ff_vld", first_fail_vld, 32'(ffv));
    check("ff_idx", first_fail_idx, 32'(ffi));
`endif
  endtask
  initial begin
    logic [31:0] held_sig, held_mm, held_pass, r;
    repeat (3) tick;
    rst_n = 1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_ready", in_ready, 0);
    check("rst_sig", final_sig, 0);
    check("rst_mm", mismatch_cnt, 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    check("rst_ffv", first_fail_vld, 0);
`endif
    in_valid = 1; in_data = 32'h1234; in_exp = 0;
    tick;
    in_valid = 0;
    check("idle_valid_sig", final_sig, 0);
    check("idle_valid_busy", busy, 0);
    fb_start = 1; fb_nv = 1; fb_es = 0;
    tick;
    fb_start = 0;
    fb_valid = 1; fb_data = 0;
    tick;
    fb_valid = 0;
    check("fb_sig", fb_sig, 32'h04C1_1DB7);
    check("fb_done", fb_done, 1);
    check("fb_pass", fb_pass, 0);
    poke = 0;
    qd = '{32'h11}; qe = '{32'h11}; qs = '{0};
    run(32'h11);
    qd = '{32'h11, 32'h0}; qe = '{32'h11, 32'h0}; qs = '{0, 3};
    run(32'h22);
    qd = '{32'h1, 32'h0, 32'h3}; qe = '{32'h1, 32'hFFFF_FFFF, 32'h3}; qs = '{0, 1, 0};
    run(sig_of());
    held_sig = final_sig; held_mm = 32'(mismatch_cnt); held_pass = 32'(pass);
    in_valid = 1; in_data = $urandom; in_exp = ~in_data;
    repeat (2) tick;
    in_valid = 0;
    check("done_hold_sig", final_sig, held_sig);
    check("done_hold_mm", mismatch_cnt, held_mm);
    check("done_hold_pass", pass, held_pass);
    check("done_hold_done", done, 1);
    for (int t = 0; t < 12; t++) begin
      int n = $urandom_range(1, 6);
      qd.delete(); qe.delete(); qs.delete();
      for (int i = 0; i < n; i++) begin
        r = $urandom;
        qd.push_back(r);
        qe.push_back($urandom_range(0, 3) == 0 ? $urandom : r);
        qs.push_back($urandom_range(0, 2));
      end
      poke = t[0];
      run($urandom_range(0, 1) ? sig_of() : $urandom);
    end
    start = 1; num_vec = 0; exp_sig = 0;
    tick;
    start = 0;
    check("nv0_done", done, 1);
    check("nv0_pass", pass, 1);
    check("nv0_sig", final_sig, 0);
    start = 1; num_vec = 0; exp_sig = 5;
    tick;
    start = 0;
    check("nv0_bad_done", done, 1);
    check("nv0_bad_pass", pass, 0);
    start = 1; num_vec = 3; exp_sig = 0;
    tick;
    start = 0;
    in_valid = 1; in_data = 32'h55; in_exp = 32'h0;
    tick;
    in_valid = 0;
    check("mid_busy", busy, 1);
    check("mid_sig", final_sig, 32'h55);
    #2 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", in_ready, 0);
    check("arst_done", done, 0);
    check("arst_sig", final_sig, 0);
    check("arst_mm", mismatch_cnt, 0);
`ifdef GATE_CHK_FIRST_FAIL_EN
    check("arst_ffv", first_fail_vld, 0);
`endif
    rst_n = 1;
    tick;
    check("arst_idle_busy", busy, 0);
    check("arst_idle_done", done, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Response-side companion to the std gate library stimulus benches.
- Consumes a stream of DUT output words and per-vector expected words, then compacts the outputs into a MISR signature.
- At the end of the run, compares the signature against an expected signature and reports pass/fail.
- Synthesizable, so gate-lib self-test can run on-chip alongside the pipelined processor.

Parameters:
- WIDTH, 32, data/signature width; vectors are declared [0:WIDTH-1], bit 0 is MSB.
- CNT_W, 8, width of vector count and mismatch counter.
- POLY, 32'h04C1_1DB7, MISR feedback polynomial (low WIDTH bits used).
- SEED, 32'h0000_0000, signature value loaded on start.

Ports:
- cycle, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse that begins a run.
- num_vec, input, CNT_W, number of vectors in the run; sampled on start.
- exp_sig, input, WIDTH, expected final signature; sampled on start.
- in_valid, input, 1, producer has a vector.
- in_ready, output, 1, checker accepts a vector.
- in_data, input, [0:WIDTH-1], DUT output word.
- in_exp, input, [0:WIDTH-1], expected DUT output word.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.
- pass, output, 1, run result; valid while done.
- mismatch_cnt, output, CNT_W, per-vector compare failures, saturating.
- final_sig, output, [0:WIDTH-1], current signature register.

Behaviour:
- One clock: cycle. Reset is asynchronous, active-low: rst_n.
- FSM states: IDLE, RUN, DONE.
- Reset (async, any state, including mid-run):
  - state=IDLE; sig=SEED; vec count=0.
  - busy, done, pass, in_ready all 0; mismatch_cnt=0.
- IDLE or DONE with start=1:
  - Latch num_vec and exp_sig; sig<=SEED; count<=0; mismatch_cnt<=0; done<=0; pass<=0.
  - If num_vec==0: next state DONE, pass=(SEED==exp_sig).
  - Otherwise: next state RUN.
- start while in RUN: ignored.
- in_ready is combinational and equals (state==RUN). busy is the same value.
- Transfer: occurs on in_valid && in_ready at a rising edge. On each transfer:
  - sig <= (sig<<1 toward bit 0, bit WIDTH-1 filled 0) ^ (sig[0] ? POLY : 0) ^ in_data.
  - If in_data != in_exp: mismatch_cnt <= mismatch_cnt + 1, saturating at all-ones.
  - count <= count + 1.
- On the transfer where count == num_vec-1: next state DONE.
  - done is asserted the cycle after the last handshake.
  - pass = (updated sig == latched exp_sig) && (final mismatch_cnt == 0), registered with the DONE entry.
- in_valid=0 in RUN: no state change; waits indefinitely; no timeout.
- DONE: done, pass, final_sig and mismatch_cnt hold until the next start or reset.
- in_valid outside RUN: ignored; no transfer.
- exp_sig and num_vec changes after start have no effect on the current run.

Optional Feature:
- Macro: GATE_CHK_FIRST_FAIL_EN.
- Defined:
  - Adds output first_fail_vld (1) and first_fail_idx (CNT_W).
  - On the first mismatching transfer of a run: first_fail_idx <= count (the 0-based index), first_fail_vld <= 1.
  - Later mismatches do not update either output.
  - Both clear on start and on reset.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset then idle: hold rst_n=0 three cycles, release -> busy=0, done=0, pass=0, in_ready=0, final_sig=0, mismatch_cnt=0.
- Single vector: start with num_vec=1, exp_sig=32'h0000_0011; send in_data=in_exp=32'h0000_0011 -> final_sig=32'h0000_0011; done=1 next cycle; pass=1; mismatch_cnt=0.
- Two vectors with a stall: num_vec=2, exp_sig=32'h0000_0022; send 32'h11, hold in_valid=0 for 3 cycles, then send 32'h00 (in_exp equal) -> final_sig=32'h22, pass=1; busy stays high during the stall.
- Feedback path: SEED=32'h8000_0000 (bit 0 set); one vector in_data=in_exp=0 -> final_sig=32'h04C1_1DB7; exp_sig=0 gives pass=0.
- Mismatch and first-fail: num_vec=3; vector 1 has in_exp=32'hFFFF_FFFF while in_data=0 -> mismatch_cnt=1, pass=0 even if exp_sig matches the signature. With GATE_CHK_FIRST_FAIL_EN: first_fail_idx=1, first_fail_vld=1.
- Async reset mid-run: after 1 of 3 transfers, pulse rst_n low between edges -> outputs clear immediately; state IDLE. start ignored during RUN is also checked, and num_vec=0 gives done one cycle after start with pass=(SEED==exp_sig).
